// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1
    } ifetch_state_e;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'd0;
    localparam logic [63:0] PC_STEP_DEFAULT  = 64'd4;

    // Low address bits cleared on a redirect so the PC stays word aligned.
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

endpackage

// File: rtl/program_counter.sv
// Program counter: reset value, sequential step, and word-aligned redirect, gated by en_i.
module program_counter
    import ifetch_pkg::*;
#(
    parameter int unsigned          WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0]  RESET_PC = WORDSIZE'(RESET_PC_DEFAULT),
    parameter logic [WORDSIZE-1:0]  PC_STEP  = WORDSIZE'(PC_STEP_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                load_i,
    input  logic [WORDSIZE-1:0] load_value_i,
    output logic [WORDSIZE-1:0] pc_o
);

    localparam logic [WORDSIZE-1:0] LOAD_MASK = ~WORDSIZE'(ALIGN_MASK);

    logic [WORDSIZE-1:0] pc_q;
    logic [WORDSIZE-1:0] pc_d;

    // Sequential step wraps silently at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            if (load_i) pc_d = load_value_i & LOAD_MASK;
            else        pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: FETCH/HOLD handshake with instruction memory and the control unit.
// Optional perf counters (fetch_count, stall_cycles) under IFETCH_PERF_COUNTERS_EN.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned          SIZE     = 32,
    parameter int unsigned          WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0]  RESET_PC = WORDSIZE'(RESET_PC_DEFAULT),
    parameter logic [WORDSIZE-1:0]  PC_STEP  = WORDSIZE'(PC_STEP_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [WORDSIZE-1:0] imem_addr,
    output logic                imem_req,
    input  logic [SIZE-1:0]     imem_rdata,
    input  logic                imem_valid,
    output logic [SIZE-1:0]     instruction,
    output logic                instr_valid,
    input  logic                instr_ack,
    input  logic                pc_load,
    input  logic [WORDSIZE-1:0] pc_load_value,
    output logic [WORDSIZE-1:0] pc
`ifdef IFETCH_PERF_COUNTERS_EN
    ,
    output logic [WORDSIZE-1:0] fetch_count,
    output logic [WORDSIZE-1:0] stall_cycles
`endif
);

    ifetch_state_e       state_q;
    logic [SIZE-1:0]     instr_q;
    logic                instr_valid_q;
    logic                pc_en;
    logic [WORDSIZE-1:0] pc_w;

    // PC only moves when the control unit retires the held instruction.
    assign pc_en = (state_q == ST_HOLD) && instr_ack;

    program_counter #(
        .WORDSIZE (WORDSIZE),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk          (clk),
        .rst          (rst),
        .en_i         (pc_en),
        .load_i       (pc_load),
        .load_value_i (pc_load_value),
        .pc_o         (pc_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ack) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_FETCH;
                    end
                end
                default: begin
                    instr_valid_q <= 1'b0;
                    state_q       <= ST_FETCH;
                end
            endcase
        end
    end

    // Gating with rst drops the request the moment reset hits, abandoning any in-flight fetch.
    assign imem_req    = (state_q == ST_FETCH) && !rst;
    assign imem_addr   = pc_w;
    assign pc          = pc_w;
    assign instruction = instr_q;
    assign instr_valid = instr_valid_q;

`ifdef IFETCH_PERF_COUNTERS_EN
    logic [WORDSIZE-1:0] fetch_count_q;
    logic [WORDSIZE-1:0] fetch_count_d;
    logic [WORDSIZE-1:0] stall_cycles_q;
    logic [WORDSIZE-1:0] stall_cycles_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        stall_cycles_d = stall_cycles_q;
        if (state_q == ST_FETCH) begin
            if (imem_valid) fetch_count_d  = fetch_count_q + 1'b1;
            else            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a cycle-level reference model and memory responder.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        pc_load = 1'b0;
    logic [63:0] pc_load_value = '0;
    logic [63:0] pc;
`ifdef IFETCH_PERF_COUNTERS_EN
    logic [63:0] fetch_count;
    logic [63:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Memory responder controls
    int mem_lat   = 0;
    bit mem_force = 1'b0;

    // Reference model state
    logic [63:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    bit          m_valid = 1'b0;
    bit          m_hold  = 1'b0;
    logic [63:0] m_fetch = '0;
    logic [63:0] m_stall = '0;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .instr_ack     (instr_ack),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .pc            (pc)
`ifdef IFETCH_PERF_COUNTERS_EN
        ,
        .fetch_count   (fetch_count),
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (a == 64'd0) ? 32'h0000_0002 : (lo ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: answers mem_lat cycles after a request appears; mem_force drives a stray valid.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_force) begin
                imem_valid = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req) begin
                if (wait_cnt >= mem_lat) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    imem_valid = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_valid = 1'b0;
                wait_cnt   = 0;
            end
        end
    end

    // Model advances on each posedge from the inputs presented in that cycle, then compares.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pc = '0; m_instr = '0; m_valid = 0; m_hold = 0;
                m_fetch = '0; m_stall = '0;
            end else if (!m_hold) begin
                if (imem_valid) begin
                    m_instr = imem_rdata;
                    m_valid = 1;
                    m_hold  = 1;
                    m_fetch = m_fetch + 1;
                end else begin
                    m_stall = m_stall + 1;
                end
            end else if (instr_ack) begin
                m_valid = 0;
                m_hold  = 0;
                m_pc    = pc_load ? {pc_load_value[63:2], 2'b00} : m_pc + 64'd4;
            end
            #1;
            if (!rst) begin
                chk("model_req",   64'(imem_req),    64'(!m_hold));
                chk("model_addr",  imem_addr,        m_pc);
                chk("model_pc",    pc,               m_pc);
                chk("model_valid", 64'(instr_valid), 64'(m_valid));
                chk("model_instr", 64'(instruction), 64'(m_instr));
`ifdef IFETCH_PERF_COUNTERS_EN
                chk("model_fetch_count",  fetch_count,  m_fetch);
                chk("model_stall_cycles", stall_cycles, m_stall);
`endif
            end
        end
    end

    task automatic wait_hold(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) begin seen = 1; break; end
        end
        chk({name, "_timeout"}, 64'(seen), 64'd1);
    endtask

    // Ack pulse issued one cycle; returns at the following negedge (now in FETCH).
    task automatic do_ack(input bit load, input logic [63:0] val);
        @(negedge clk);
        instr_ack = 1'b1; pc_load = load; pc_load_value = val;
        @(negedge clk);
        instr_ack = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        logic [31:0] held;
`ifdef IFETCH_PERF_COUNTERS_EN
        logic [63:0] f0, s0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req",   64'(imem_req),    64'd0);
        chk("rst_pc",    pc,               64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req",  64'(imem_req), 64'd1);
        chk("post_rst_addr", imem_addr,     64'd0);

        // Zero-wait first fetch
        @(posedge clk); #1;
        chk("first_valid", 64'(instr_valid), 64'd1);
        chk("first_instr", 64'(instruction), 64'h2);
        chk("first_pc",    pc,               64'd0);

        // Redirect to 0x10, then sequential ack
        do_ack(1, 64'h10);
        wait_hold("hold_10");
        do_ack(0, 64'h0);
        chk("seq_valid", 64'(instr_valid), 64'd0);
        chk("seq_pc",    pc,               64'h14);
        chk("seq_req",   64'(imem_req),    64'd1);
        chk("seq_addr",  imem_addr,        64'h14);
        wait_hold("hold_14");
        chk("seq_instr", 64'(instruction), 64'h14 ^ 64'hC0DE_0000);

        // Misaligned redirect
        do_ack(1, 64'h103);
        chk("load_pc",   pc,        64'h100);
        chk("load_addr", imem_addr, 64'h100);
        wait_hold("hold_100");

        // 3-cycle memory latency
        mem_lat = 2;
`ifdef IFETCH_PERF_COUNTERS_EN
        f0 = fetch_count; s0 = stall_cycles;
`endif
        do_ack(1, 64'h200);
        req_cycles = 0;
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            if (imem_req) req_cycles++;
            chk("lat_pc_stable", pc, 64'h200);
            @(negedge clk);
        end
        chk("lat_req_cycles", 64'(req_cycles), 64'd3);
        chk("lat_valid",      64'(instr_valid), 64'd1);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("lat_stall_delta", stall_cycles - s0, 64'd2);
        chk("lat_fetch_delta", fetch_count - f0,  64'd1);
`endif

        // Ack during FETCH is ignored
        do_ack(0, 64'h0);
        chk("fetch_pc", pc, 64'h204);
        instr_ack = 1'b1; pc_load = 1'b1; pc_load_value = 64'h900;
        @(negedge clk);
        instr_ack = 1'b0; pc_load = 1'b0;
        chk("ack_in_fetch_pc",    pc,               64'h204);
        chk("ack_in_fetch_valid", 64'(instr_valid), 64'd0);
        wait_hold("hold_204");
        held = instruction;
        chk("hold_204_instr", 64'(held), 64'h204 ^ 64'hC0DE_0000);

        // pc_load without ack in HOLD is ignored
        pc_load = 1'b1; pc_load_value = 64'h800;
        repeat (2) @(negedge clk);
        pc_load = 1'b0;
        chk("load_noack_pc",    pc,               64'h204);
        chk("load_noack_valid", 64'(instr_valid), 64'd1);
        chk("load_noack_instr", 64'(instruction), 64'(held));

        // Stray valid together with ack in HOLD: only the ack acts
        mem_lat = 0;
        @(negedge clk);
        mem_force = 1'b1;
        #2;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0; mem_force = 1'b0;
        chk("both_valid", 64'(instr_valid), 64'd0);
        chk("both_pc",    pc,               64'h208);
        chk("both_instr", 64'(instruction), 64'(held));
        wait_hold("hold_208");

        // PC wrap at top of address space
        do_ack(1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_hold("hold_top");
        do_ack(0, 64'h0);
        chk("wrap_pc", pc, 64'd0);
        wait_hold("hold_wrap");

        // Reset in the middle of a stalled fetch
        mem_lat = 5;
        do_ack(1, 64'h40);
        @(negedge clk);
        chk("pre_rst_req", 64'(imem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req",   64'(imem_req),    64'd0);
        chk("midrst_pc",    pc,               64'd0);
        chk("midrst_valid", 64'(instr_valid), 64'd0);
        @(negedge clk);
        mem_force = 1'b1;
        @(posedge clk); #1;
        chk("late_valid_ignored", 64'(instr_valid), 64'd0);
        @(negedge clk);
        mem_force = 1'b0; mem_lat = 0;
        rst = 1'b0;
        wait_hold("hold_after_rst");
        chk("after_rst_instr", 64'(instruction), 64'h2);
        chk("after_rst_pc",    pc,               64'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream stage of the multi-cycle datapath. Owns the program counter and fetches 32-bit words from instruction memory over a req/valid handshake. Holds each fetched word stable in an instruction register for the control unit. Advances or redirects the PC only when the control unit acknowledges completion of the current instruction.

Parameters:
SIZE, 32, instruction width in bits
WORDSIZE, 64, PC / instruction-memory address width in bits
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, byte increment applied to the PC on sequential advance

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
imem_addr  output  WORDSIZE  instruction memory byte address; equals pc
imem_req  output  1  fetch request, held high until imem_valid is sampled
imem_rdata  input  SIZE  instruction word from memory
imem_valid  input  1  imem_rdata valid this cycle
instruction  output  SIZE  registered instruction, to control unit
instr_valid  output  1  instruction register holds a word not yet acknowledged
instr_ack  input  1  control unit has finished the current instruction (1-cycle pulse)
pc_load  input  1  redirect request, sampled only together with instr_ack
pc_load_value  input  WORDSIZE  redirect target address
pc  output  WORDSIZE  address of the current / held instruction

Behaviour:
- Reset is asynchronous and active-high; one clock, clk. During and immediately after rst: state=FETCH, pc=RESET_PC, instruction=0, instr_valid=0.
- imem_req is a Moore output (state==FETCH), so it is 1 in the first cycle after rst deasserts.
- imem_addr=pc at all times.
- FSM states: FETCH, HOLD (encoding in package).
- FETCH:
  - imem_req=1.
  - On a posedge with imem_valid=1: instruction<=imem_rdata, instr_valid<=1, state<=HOLD.
  - Otherwise remain in FETCH with unbounded wait and pc unchanged.
- HOLD:
  - imem_req=0. instruction and pc stay stable. imem_valid is ignored.
  - On a posedge with instr_ack=1: instr_valid<=0, state<=FETCH, and the PC updates:
    - pc_load=1: pc<=pc_load_value with bits [1:0] forced to 0.
    - pc_load=0: pc<=pc+PC_STEP, truncated to WORDSIZE. Wrap from all-ones region to 0 is legal and silent.
- Latency: with a zero-wait memory (imem_valid=1 in the same cycle as imem_req), instruction is valid 1 cycle after entering FETCH. Ack-to-next-instr_valid is 2 cycles minimum.
- Boundary and error conditions:
  - instr_ack in FETCH: ignored. No PC change, no error.
  - pc_load without instr_ack: ignored.
  - imem_valid and instr_ack asserted in the same cycle while in HOLD: only the ack acts.
  - rst mid-fetch: imem_req drops asynchronously and the in-flight response is discarded. Memory must tolerate request abandonment.
- The control unit samples instruction only while instr_valid=1. instruction never changes while instr_valid=1.

Optional Feature:
- Macro IFETCH_PERF_COUNTERS_EN.
- When defined, adds two output ports:
  - fetch_count (WORDSIZE): increments on every FETCH->HOLD transition.
  - stall_cycles (WORDSIZE): increments every cycle with state==FETCH and imem_valid=0.
- Both counters reset to 0 on rst, wrap modulo 2^WORDSIZE, and are unaffected by pc_load.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package ifetch_pkg:
  - FSM state encodings (2-bit: FETCH, HOLD).
  - Default constants RESET_PC_DEFAULT and PC_STEP_DEFAULT.
  - Alignment mask constant.
- One natural sub-module, program_counter: holds pc and implements reset, increment by PC_STEP, aligned load, and the update enable.
- The FSM and instruction register stay in instruction_fetch.

Test Plan:
- Reset, zero-wait memory returning 0x00000002 at addr 0 -> after rst falls: imem_req=1, addr=0; next cycle instr_valid=1, instruction=0x00000002, pc=0.
- Memory with 3-cycle latency -> imem_req held high 3 cycles, pc stable at 0. With the feature enabled, stall_cycles=2 and fetch_count=1.
- Ack without load in HOLD at pc=0x10 -> instr_valid=0 next cycle, pc=0x14, imem_req=1, imem_addr=0x14.
- Ack with pc_load=1, pc_load_value=0x103 -> pc=0x100, next fetch at 0x100.
- Ack pulse during FETCH and pc_load without ack in HOLD -> pc unchanged, state unchanged, instruction unchanged.
- pc=0xFFFF_FFFF_FFFF_FFFC with ack and no load -> pc=0. Separately, rst asserted mid-FETCH -> imem_req=0 immediately, pc=RESET_PC, instr_valid=0, and a late imem_valid is ignored.
